// File: rtl/keypad_pkg.sv
// Shared keypad definitions: key-code constants, the 4x4 layout lookup and
// the one-cold legality check used when decoding scanner coordinates.
package keypad_pkg;

  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  // Exactly one bit low: the inverted nibble is a nonzero power of two.
  function automatic logic is_one_cold(input logic [3:0] n);
    logic [3:0] inv;
    inv = ~n;
    return (inv != 4'h0) && ((inv & (inv - 4'h1)) == 4'h0);
  endfunction

  // Index of the low bit, counted from the MSB (bit 3 low -> 0).
  function automatic logic [1:0] cold_idx(input logic [3:0] n);
    logic [1:0] idx;
    case (n)
      4'b0111: idx = 2'd0;
      4'b1011: idx = 2'd1;
      4'b1101: idx = 2'd2;
      default: idx = 2'd3;
    endcase
    return idx;
  endfunction

  // Rows: 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D
  function automatic logic [3:0] key_code(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = KEY_STAR;
      4'hD: code = 4'h0;
      4'hE: code = KEY_HASH;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through FIFO; the head word is visible on rd_data whenever
// the FIFO is non-empty. Pops while empty are ignored.
module sync_fifo_fwft #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             push, pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CNT_W'(DEPTH));
  assign count   = count_q;
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    pop      = rd_en & ~empty;
    push     = wr_en & (~full | pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = wr_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: rd_data is masked while empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/keypad_key_fifo.sv
// Keypad press decoder feeding a FWFT key FIFO with sticky overflow.
// Define KEYPAD_NUM_ACCUM_EN to add the decimal number-entry accumulator.
module keypad_key_fifo
  import keypad_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
`ifdef KEYPAD_NUM_ACCUM_EN
  output logic [31:0]      num_data,
  output logic             num_valid,
  input  logic             num_ack,
`endif
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       key_coord,
  input  logic             rd_en,
  output logic [3:0]       rd_data,
  output logic             empty,
  output logic             full,
  output logic [CNT_W-1:0] count,
  output logic             overflow,
  input  logic             clr_ovf,
  output logic             invalid_key
);

  logic       dec_vld_q, dec_vld_d;
  logic [3:0] dec_code_q, dec_code_d;
  logic       inv_q, inv_d;
  logic       ovf_q, ovf_d;
  logic       legal, press, wr_en, drop;

  always_comb begin
    press      = |key_coord;
    legal      = is_one_cold(key_coord[7:4]) & is_one_cold(key_coord[3:0]);
    dec_vld_d  = press & legal;
    inv_d      = press & ~legal;
    dec_code_d = key_code(cold_idx(key_coord[3:0]), cold_idx(key_coord[7:4]));
    // A full FIFO still accepts the push when the same cycle pops.
    wr_en      = dec_vld_q & (~full | rd_en);
    drop       = dec_vld_q & full & ~rd_en;
    ovf_d      = ovf_q;
    if (clr_ovf) ovf_d = 1'b0;
    if (drop)    ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_vld_q  <= 1'b0;
      dec_code_q <= '0;
      inv_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      dec_vld_q  <= dec_vld_d;
      dec_code_q <= dec_code_d;
      inv_q      <= inv_d;
      ovf_q      <= ovf_d;
    end
  end

  assign overflow    = ovf_q;
  assign invalid_key = inv_q;

  sync_fifo_fwft #(.WIDTH(4), .DEPTH(DEPTH), .CNT_W(CNT_W)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data (dec_code_q),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .empty   (empty),
    .full    (full),
    .count   (count)
  );

`ifdef KEYPAD_NUM_ACCUM_EN
  logic [31:0] acc_q, acc_d, num_data_q, num_data_d;
  logic        num_valid_q, num_valid_d;

  // Runs off the decode stage, so keys dropped by a full FIFO still count.
  always_comb begin
    acc_d       = acc_q;
    num_data_d  = num_data_q;
    num_valid_d = num_valid_q;
    if (num_ack) num_valid_d = 1'b0;
    if (dec_vld_q) begin
      if (dec_code_q == KEY_STAR) begin
        acc_d = '0;
      end else if (dec_code_q == KEY_HASH) begin
        num_data_d  = acc_q;
        num_valid_d = 1'b1;
        acc_d       = '0;
      end else if (dec_code_q <= 4'h9) begin
        acc_d = (acc_q << 3) + (acc_q << 1) + {28'h0, dec_code_q};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q       <= '0;
      num_data_q  <= '0;
      num_valid_q <= 1'b0;
    end else begin
      acc_q       <= acc_d;
      num_data_q  <= num_data_d;
      num_valid_q <= num_valid_d;
    end
  end

  assign num_data  = num_data_q;
  assign num_valid = num_valid_q;
`endif

endmodule

// File: tb/tb_keypad_key_fifo.sv
// Directed bench for keypad_key_fifo: queue-based reference model compared
// every cycle, plus literal expectations for the documented scenarios.
module tb_keypad_key_fifo;

  localparam int DEPTH = 8;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [7:0]       key_coord;
  logic             rd_en, clr_ovf;
  logic [3:0]       rd_data;
  logic             empty, full, overflow, invalid_key;
  logic [CNT_W-1:0] count;
`ifdef KEYPAD_NUM_ACCUM_EN
  logic [31:0]      num_data;
  logic             num_valid;
  logic             num_ack;
`endif

  int tests = 0;
  int fails = 0;

  keypad_key_fifo #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
`ifdef KEYPAD_NUM_ACCUM_EN
    .num_data    (num_data),
    .num_valid   (num_valid),
    .num_ack     (num_ack),
`endif
    .clk         (clk),
    .rst_n       (rst_n),
    .key_coord   (key_coord),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .empty       (empty),
    .full        (full),
    .count       (count),
    .overflow    (overflow),
    .clr_ovf     (clr_ovf),
    .invalid_key (invalid_key)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int layout [16] = '{1, 2, 3, 10, 4, 5, 6, 11, 7, 8, 9, 12, 14, 0, 15, 13};
  int m_q [$];
  bit m_pend_v, m_ovf, m_inv;
  int m_pend_c;

  function automatic int zero_pos(input logic [3:0] n);
    int cnt, idx;
    cnt = 0;
    idx = -1;
    for (int b = 0; b < 4; b++)
      if (!n[3-b]) begin
        cnt++;
        idx = b;
      end
    return (cnt == 1) ? idx : -1;
  endfunction

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_q.delete();
        m_pend_v = 0;
        m_ovf    = 0;
        m_inv    = 0;
      end else begin
        int r, c;
        bit dropped;
        dropped = 0;
        if (rd_en && m_q.size() > 0) void'(m_q.pop_front());
        if (m_pend_v) begin
          if (m_q.size() < DEPTH) m_q.push_back(m_pend_c);
          else dropped = 1;
        end
        if (dropped) m_ovf = 1;
        else if (clr_ovf) m_ovf = 0;
        r = zero_pos(key_coord[3:0]);
        c = zero_pos(key_coord[7:4]);
        m_pend_v = (key_coord != 0) && r >= 0 && c >= 0;
        m_inv    = (key_coord != 0) && !(r >= 0 && c >= 0);
        m_pend_c = m_pend_v ? layout[r*4+c] : 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      chk("cmp_rd_data", int'(rd_data), (m_q.size() > 0) ? m_q[0] : 0);
      chk("cmp_empty", int'(empty), int'(m_q.size() == 0));
      chk("cmp_full", int'(full), int'(m_q.size() == DEPTH));
      chk("cmp_count", int'(count), m_q.size());
      chk("cmp_overflow", int'(overflow), int'(m_ovf));
      chk("cmp_invalid", int'(invalid_key), int'(m_inv));
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic [7:0] k, input logic r, input logic c);
    @(negedge clk);
    key_coord = k;
    rd_en     = r;
    clr_ovf   = c;
`ifdef KEYPAD_NUM_ACCUM_EN
    num_ack   = 1'b0;
`endif
  endtask

  task automatic pop_expect(input int exp, input string name);
    chk(name, int'(rd_data), exp);
    rd_en = 1'b1;
    cyc(8'h00, 1'b0, 1'b0);
  endtask

  logic [7:0] digit_coord [10] = '{8'hBE, 8'h77, 8'hB7, 8'hD7, 8'h7B, 8'hBB, 8'hDB, 8'h7D, 8'hBD, 8'hDD};
  int         ord_exp [4]      = '{0, 15, 10, 14};
  logic [7:0] ord_coord [4]    = '{8'hBE, 8'hDE, 8'hE7, 8'h7E};

  initial begin
    rst_n = 1'b0; key_coord = 8'h00; rd_en = 1'b0; clr_ovf = 1'b0;
`ifdef KEYPAD_NUM_ACCUM_EN
    num_ack = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_empty", int'(empty), 1);
    chk("rst_count", int'(count), 0);
    chk("rst_rd_data", int'(rd_data), 0);
    chk("rst_full", int'(full), 0);
    chk("rst_ovf", int'(overflow), 0);
    rst_n = 1'b1;

    // single press latency
    cyc(8'h77, 0, 0);
    cyc(8'h00, 0, 0);
    chk("single_empty_n", int'(empty), 1);
    cyc(8'h00, 0, 0);
    chk("single_empty", int'(empty), 0);
    chk("single_rd_data", int'(rd_data), 1);
    chk("single_count", int'(count), 1);
    pop_expect(1, "single_pop");
    chk("single_empty_after", int'(empty), 1);

    // ordering, back-to-back presses
    for (int i = 0; i < 4; i++) cyc(ord_coord[i], 0, 0);
    cyc(8'h00, 0, 0);
    cyc(8'h00, 0, 0);
    chk("order_count", int'(count), 4);
    for (int i = 0; i < 4; i++) pop_expect(ord_exp[i], "order_pop");

    // invalid press
    cyc(8'h73, 0, 0);
    cyc(8'h00, 0, 0);
    chk("invalid_pulse", int'(invalid_key), 1);
    cyc(8'h00, 0, 0);
    chk("invalid_clear", int'(invalid_key), 0);
    chk("invalid_count", int'(count), 0);
    cyc(8'hFE, 0, 0);
    cyc(8'h00, 0, 0);
    chk("invalid_col", int'(invalid_key), 1);

    // overflow: keys 1..8 fill, 9 dropped
    for (int i = 1; i <= DEPTH + 1; i++) cyc(digit_coord[i], 0, 0);
    cyc(8'h00, 0, 0);
    cyc(8'h00, 0, 0);
    chk("ovf_full", int'(full), 1);
    chk("ovf_set", int'(overflow), 1);
    chk("ovf_count", int'(count), DEPTH);
    cyc(8'h00, 0, 1);
    cyc(8'h00, 0, 0);
    chk("ovf_cleared", int'(overflow), 0);
    // clear and new drop in the same cycle: set wins
    cyc(8'h77, 0, 0);
    cyc(8'h00, 0, 1);
    cyc(8'h00, 0, 0);
    chk("ovf_set_wins", int'(overflow), 1);
    cyc(8'h00, 0, 1);
    // full + push + pop in the same cycle
    cyc(8'hBE, 0, 0);
    chk("fullpp_head", int'(rd_data), 1);
    cyc(8'h00, 1, 0);
    cyc(8'h00, 0, 0);
    chk("fullpp_count", int'(count), DEPTH);
    chk("fullpp_ovf", int'(overflow), 0);
    for (int i = 2; i <= DEPTH; i++) pop_expect(i, "ovf_drain");
    pop_expect(0, "ovf_drain_last");
    chk("ovf_drained", int'(empty), 1);

`ifdef KEYPAD_NUM_ACCUM_EN
    cyc(8'h77, 0, 0); cyc(8'hB7, 0, 0); cyc(8'hD7, 0, 0); cyc(8'hDE, 0, 0);
    cyc(8'h00, 0, 0); cyc(8'h00, 0, 0);
    chk("acc_valid", int'(num_valid), 1);
    chk("acc_123", int'(num_data), 123);
    num_ack = 1'b1;
    cyc(8'h00, 0, 0);
    chk("acc_ack", int'(num_valid), 0);
    for (int i = 0; i < 4; i++) pop_expect(int'(i < 3 ? i + 1 : 15), "acc_fifo");
    cyc(8'h77, 0, 0); cyc(8'h7E, 0, 0); cyc(8'h7B, 0, 0); cyc(8'hDE, 0, 0);
    cyc(8'h00, 0, 0); cyc(8'h00, 0, 0);
    chk("acc_star_valid", int'(num_valid), 1);
    chk("acc_star_4", int'(num_data), 4);
    for (int i = 0; i < 4; i++) pop_expect(ord_exp[(i == 0) ? 0 : 0] * 0 + ((i == 0) ? 1 : (i == 1) ? 14 : (i == 2) ? 4 : 15), "acc_fifo2");
`endif

    // async reset with 3 entries queued
    cyc(8'h77, 0, 0); cyc(8'hB7, 0, 0); cyc(8'hD7, 0, 0);
    cyc(8'h00, 0, 0); cyc(8'h00, 0, 0);
    chk("pre_rst_count", int'(count), 3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_empty", int'(empty), 1);
    chk("async_rst_count", int'(count), 0);
    chk("async_rst_rd_data", int'(rd_data), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(8'h00, 0, 0);
    cyc(8'h00, 0, 0);
    chk("post_rst_empty", int'(empty), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/keypad_key_fifo.md
# keypad_key_fifo

Consumer side of the 4x4 keypad scanner. Takes the one-cycle `key_coord` press events from the scanner and decodes each {column, row} one-cold pair into a 4-bit key code. Valid codes are queued in a first-word-fall-through FIFO so the CPU MMIO layer can read keys without losing presses between polls. Optionally, decimal number entry is assembled in hardware.

## Interface
- `DEPTH`, 8: FIFO entries; must be a power of two, minimum 2.
- `CNT_W`, $clog2(DEPTH)+1: width of `count`.
- `clk` input 1: system clock; all state updates on the rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `key_coord` input 8: {col_out[3:0], row_in[3:0]} from the scanner.
  - 8'h00 means no event.
  - Nonzero is a press, lasting exactly one cycle.
  - The scanner updates on the falling edge, so the value is stable at the rising edge.
- `rd_en` input 1: pop the head entry; ignored while `empty`.
- `rd_data` output 4: head key code; valid while `!empty`; 4'h0 when empty.
- `empty` output 1: FIFO holds no entries.
- `full` output 1: FIFO holds `DEPTH` entries.
- `count` output CNT_W: number of entries held.
- `overflow` output 1: sticky; set when a press was dropped because the FIFO was full.
- `clr_ovf` input 1: clears `overflow`.
- `invalid_key` output 1: one-cycle pulse when `key_coord` is not a legal one-cold/one-cold pair.

## Operation
- **Row/column numbering.** `col_out[3]`=0 selects col1 … `col_out[0]`=0 selects col4. `row_in[3]`=0 selects row1 … `row_in[0]`=0 selects row4.
- **Layout, row1 to row4:** 1 2 3 A / 4 5 6 B / 7 8 9 C / * 0 # D.
- **Key codes:**
  - Digits map to 0x0–0x9.
  - A–D map to 0xA–0xD.
  - `*` maps to 0xE; `#` maps to 0xF.
- **Legality check.** Both nibbles must each have exactly one zero bit. Otherwise the press is dropped, nothing is pushed, and `invalid_key` pulses.
- **Stage 1 (decode register).** On the edge sampling a nonzero `key_coord`, store the code and a valid bit.
- **Stage 2 (FIFO write).** On the next edge, push the stored code if the FIFO is not full or `rd_en` pops in the same cycle. Otherwise drop the code and set `overflow`.
- **Push and pop together:**
  - While full: both take effect, `count` is unchanged, `overflow` stays as is.
  - While empty: the pop is ignored and the push takes effect.
- **Pointers.** Read and write pointers are log2(DEPTH) bits and wrap naturally. Full/empty are derived from `count`.
- **`overflow` priority.** `clr_ovf` and a new drop in the same cycle leave `overflow`=1 (set wins).

## Timing
- Reset values: `rd_data`=0, `empty`=1, `full`=0, `count`=0, `overflow`=0, `invalid_key`=0. The decode register is cleared and the pointers are zeroed.
- Latency: press sampled at edge N → `empty` falls and `rd_data` is valid after edge N+1.
- `invalid_key` is high for the cycle following edge N.
- `rd_en` at edge M → the next head appears after edge M (FWFT), or `empty` rises.
- Back-to-back presses on consecutive cycles are all accepted. The scanner cannot produce them, but they must not be lost.
- Reset asserted mid-operation discards the queued keys and any in-flight decode immediately.

## Configuration
- `KEYPAD_NUM_ACCUM_EN` **defined:** adds a 32-bit decimal accumulator and ports `num_data` output 32, `num_valid` output 1, `num_ack` input 1.
  - Digit key: `acc <= acc*10 + d`, computed as (acc<<3)+(acc<<1)+d, modulo 2^32 (wraps, no saturation).
  - `*`: clears `acc`.
  - `#`: loads `num_data <= acc`, sets `num_valid`, clears `acc`.
  - `num_ack` clears `num_valid`. A `#` in the same cycle as `num_ack` wins: new data, `num_valid` stays 1.
  - A `#` while already valid overwrites `num_data`.
  - The accumulator updates at the Stage 2 edge, independent of FIFO full.
  - All keys are still pushed to the FIFO.
  - Reset values: `acc`=0, `num_data`=0, `num_valid`=0.
- **Undefined:** no accumulator logic and no extra ports.

## Structure
- Package `keypad_pkg`:
  - Key-code localparams `KEY_STAR`=4'hE, `KEY_HASH`=4'hF.
  - The 16-entry row/column→code layout function.
  - The one-cold legality function.
- Sub-module `sync_fifo_fwft` (parameters `WIDTH`, `DEPTH`): storage, pointers, `count`, full/empty.
- The top level holds decode, overflow and the optional accumulator.

## Test plan
- **Single press:** `key_coord`=8'h77 for one cycle → two edges later `empty`=0, `rd_data`=4'h1, `count`=1; `rd_en` → `empty`=1.
- **Ordering:** 8'hBE, 8'hDE, 8'hE7, 8'h7E → popped `rd_data` sequence 0x0, 0xF, 0xA, 0xE.
- **Invalid press:** 8'h73 → `invalid_key` pulses one cycle, `count` unchanged.
- **Overflow:** DEPTH+1 presses with no reads → `full`=1, `overflow`=1, first DEPTH codes intact.
  - Full + press + `rd_en` in one cycle → `count`=DEPTH, no new overflow.
  - `clr_ovf` clears `overflow`.
- **Accumulator (macro defined):** keys 1,2,3,# → `num_valid`=1, `num_data`=123. `*` mid-entry (1,*,4,#) → 4.
- **Reset mid-operation:** async `rst_n` low with 3 entries queued → `empty`=1, `count`=0 immediately, no clock edge required.
